// File: rtl/nn_program_loader.sv
// nn_program_loader
// Boot-time writer for the NN CPU instruction memory. Consumes a byte stream
// {count[15:8], count[7:0], 4 bytes per big-endian instruction, XOR checksum},
// writes each assembled word to consecutive addresses from 0, and keeps the CPU
// held until the checksum matches. It then releases the CPU with a one-cycle
// cpu_start.
//
// Ports:
//   CLK, RST_N         clock, synchronous active-low reset
//   rx_valid/rx_data   byte source, transfer when rx_valid & rx_ready
//   rx_ready           loader can take a byte (state-decoded)
//   load_req           restart request, honoured only in DONE / ERROR
//   im_we/im_addr/im_wdata  instruction memory write port (registered)
//   cpu_hold           1 = CPU must not fetch
//   cpu_start          one-cycle pulse on release of a verified image
//   done / err         load succeeded / failed
//   words_loaded       words written so far
module nn_program_loader #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  load_req,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [BUS_WIDTH-1:0]  im_wdata,
  output logic                  cpu_hold,
  output logic                  cpu_start,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_WORD, S_CSUM, S_DONE, S_ERROR
  } state_t;

  // Largest legal count is the full memory depth.
  localparam logic [16:0] MAX_COUNT = 17'(1) << ADDR_WIDTH;

  state_t state_q, state_d;

  logic [15:0]           count_q, count_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           shift_q, shift_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  im_we_q, im_we_d;
  logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
  logic [BUS_WIDTH-1:0]  im_wdata_q, im_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  cpu_start_q, cpu_start_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [15:0]           hdr_count;
  logic [ADDR_WIDTH:0]   words_inc;
  logic                  last_word;
  logic                  count_over;

  assign accept     = rx_valid & rx_ready;
  // Full count as it would be once the low header byte is taken.
  assign hdr_count  = {count_q[15:8], rx_data};
  assign count_over = ({1'b0, hdr_count} > MAX_COUNT);
  assign words_inc  = words_q + 1'b1;
  assign last_word  = (17'(words_inc) == {1'b0, count_q});

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_HDR_HI;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_HI: if (accept) state_d = S_HDR_LO;
      S_HDR_LO: if (accept) begin
        if (count_over)            state_d = S_ERROR;
        else if (hdr_count == '0)  state_d = S_CSUM;
        else                       state_d = S_WORD;
      end
      S_WORD:   if (accept && byte_idx_q == 2'd3 && last_word) state_d = S_CSUM;
      S_CSUM:   if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR:  if (load_req) state_d = S_HDR_HI;
      default:  state_d = S_HDR_HI;
    endcase
  end

  // Output decode: only rx_ready is combinational, and only from the state.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_HDR_HI, S_HDR_LO, S_WORD, S_CSUM: rx_ready = 1'b1;
      default:                            rx_ready = 1'b0;
    endcase
  end

  // Datapath next-state
  always_comb begin
    count_d     = count_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    words_d     = words_q;
    im_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    cpu_start_d = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    case (state_q)
      S_HDR_HI: if (accept) begin
        count_d[15:8] = rx_data;
        csum_d        = csum_q ^ rx_data;
      end
      S_HDR_LO: if (accept) begin
        count_d[7:0] = rx_data;
        csum_d       = csum_q ^ rx_data;
        byte_idx_d   = 2'd0;
        if (count_over) err_d = 1'b1;
      end
      S_WORD: if (accept) begin
        csum_d = csum_q ^ rx_data;
        if (byte_idx_q == 2'd3) begin
          im_wdata_d = {shift_q, rx_data};
          im_addr_d  = words_q[ADDR_WIDTH-1:0];
          im_we_d    = 1'b1;
          words_d    = words_inc;
          byte_idx_d = 2'd0;
        end else begin
          // Big-endian: earlier bytes move toward the top of the word.
          shift_d    = {shift_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      S_CSUM: if (accept) begin
        if (rx_data == csum_q) begin
          done_d      = 1'b1;
          cpu_hold_d  = 1'b0;
          cpu_start_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      S_DONE, S_ERROR: if (load_req) begin
        done_d     = 1'b0;
        err_d      = 1'b0;
        words_d    = '0;
        csum_d     = '0;
        count_d    = '0;
        byte_idx_d = 2'd0;
        cpu_hold_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_q     <= '0;
      byte_idx_q  <= 2'd0;
      shift_q     <= '0;
      csum_q      <= '0;
      words_q     <= '0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      cpu_hold_q  <= 1'b1;
      cpu_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      words_q     <= words_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      cpu_start_q <= cpu_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign cpu_start    = cpu_start_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_nn_program_loader.sv
// Testbench for nn_program_loader: drives byte images, keeps a queue of the
// instruction-memory writes each image should produce, and compares every
// observed write against the queue head.
module tb_nn_program_loader;

  typedef logic [7:0] bytes_t[$];

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        load_req;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        cpu_start;
  logic        done;
  logic        err;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [39:0] exp_q[$];

  nn_program_loader #(.BUS_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .load_req(load_req), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .cpu_start(cpu_start), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  // Write monitor: every im_we pulse must match the next expected write.
  always @(negedge CLK) begin
    if (im_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h expected none", im_addr, im_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({im_addr, im_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   im_addr, im_wdata, e[39:32], e[31:0]);
        end else begin
          $display("write addr=%0d data=%h", im_addr, im_wdata);
        end
      end
    end
    if (cpu_start === 1'b1) start_cnt++;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      errors++;
      $display("FAIL rx_ready_timeout byte=%h got rx_ready=%b expected 1", b, rx_ready);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  // Pushes the writes the image should cause, then streams all but the last
  // n_hold bytes (the caller sends those itself to check release timing).
  task automatic send_image(input bytes_t img, input int gap_max, input int n_hold);
    int cnt;
    cnt = {img[0], img[1]};
    if (cnt <= 256) begin
      for (int i = 0; i < cnt; i++) begin
        if (2 + 4*i + 3 < img.size())
          exp_q.push_back({8'(i), img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]});
      end
    end
    for (int i = 0; i < img.size() - n_hold; i++)
      send_byte(img[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  function automatic bytes_t first_image();
    bytes_t q;
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA0, 8'h00, 8'h00, 8'h01, 8'hAB};
    return q;
  endfunction

  task automatic test_reset();
    RST_N = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; load_req = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    checks += 9;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b expected 1", rx_ready); end
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %b expected 1", cpu_hold); end
    if (im_we !== 1'b0) begin errors++; $display("FAIL reset_im_we got %b expected 0", im_we); end
    if (im_addr !== 8'd0) begin errors++; $display("FAIL reset_im_addr got %h expected 0", im_addr); end
    if (im_wdata !== 32'd0) begin errors++; $display("FAIL reset_im_wdata got %h expected 0", im_wdata); end
    if (cpu_start !== 1'b0) begin errors++; $display("FAIL reset_cpu_start got %b expected 0", cpu_start); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err); end
    if (words_loaded !== 9'd0) begin errors++; $display("FAIL reset_words got %0d expected 0", words_loaded); end
    $display("reset checked");
  endtask

  task automatic test_good_image();
    int s0;
    s0 = start_cnt;
    send_image(first_image(), 0, 1);
    checks += 2;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL good_hold_before_csum got %b expected 1", cpu_hold); end
    if (done !== 1'b0) begin errors++; $display("FAIL good_done_before_csum got %b expected 0", done); end
    send_byte(8'hAB, 0);
    checks += 3;
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL good_hold_release got %b expected 0", cpu_hold); end
    if (cpu_start !== 1'b1) begin errors++; $display("FAIL good_start_pulse got %b expected 1", cpu_start); end
    if (done !== 1'b1) begin errors++; $display("FAIL good_done got %b expected 1", done); end
    tick(); tick();
    checks += 5;
    if (cpu_start !== 1'b0) begin errors++; $display("FAIL good_start_width got %b expected 0", cpu_start); end
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL good_start_count got %0d expected 1", start_cnt - s0); end
    if (words_loaded !== 9'd2) begin errors++; $display("FAIL good_words got %0d expected 2", words_loaded); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL good_writes_missing got %0d pending expected 0", exp_q.size()); end
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL good_rx_ready got %b expected 0", rx_ready); end
    $display("good image: done=%b words=%0d", done, words_loaded);
  endtask

  task automatic test_bad_checksum();
    bytes_t img;
    int s0;
    pulse_load_req();
    checks += 3;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reload_hold got %b expected 1", cpu_hold); end
    if (words_loaded !== 9'd0) begin errors++; $display("FAIL reload_words got %0d expected 0", words_loaded); end
    if (done !== 1'b0) begin errors++; $display("FAIL reload_done got %b expected 0", done); end
    s0 = start_cnt;
    img = first_image();
    img[10] = 8'hAC;
    send_image(img, 0, 0);
    // Hold rx_valid while not ready: nothing may be consumed or written.
    rx_valid = 1'b1; rx_data = 8'h55;
    tick(); tick(); tick();
    rx_valid = 1'b0;
    checks += 7;
    if (err !== 1'b1) begin errors++; $display("FAIL bad_err got %b expected 1", err); end
    if (done !== 1'b0) begin errors++; $display("FAIL bad_done got %b expected 0", done); end
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL bad_hold got %b expected 1", cpu_hold); end
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL bad_rx_ready got %b expected 0", rx_ready); end
    if (start_cnt !== s0) begin errors++; $display("FAIL bad_start got %0d pulses expected 0", start_cnt - s0); end
    if (words_loaded !== 9'd2) begin errors++; $display("FAIL bad_words got %0d expected 2", words_loaded); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL bad_writes_missing got %0d pending expected 0", exp_q.size()); end
    $display("bad checksum: err=%b", err);
  endtask

  task automatic test_count_limits();
    bytes_t img;
    logic [7:0] cs;
    logic [31:0] w;
    pulse_load_req();
    img = '{8'h01, 8'h01};
    send_image(img, 0, 0);
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL over_err got %b expected 1", err); end
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL over_rx_ready got %b expected 0", rx_ready); end
    if (words_loaded !== 9'd0) begin errors++; $display("FAIL over_words got %0d expected 0", words_loaded); end
    $display("count 257 rejected: err=%b", err);
    pulse_load_req();
    img = '{8'h01, 8'h00};
    cs = 8'h01;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      for (int k = 3; k >= 0; k--) begin
        img.push_back(w[8*k +: 8]);
        cs ^= w[8*k +: 8];
      end
    end
    img.push_back(cs);
    send_image(img, 0, 0);
    tick();
    checks += 4;
    if (done !== 1'b1) begin errors++; $display("FAIL full_done got %b expected 1", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL full_err got %b expected 0", err); end
    if (words_loaded !== 9'd256) begin errors++; $display("FAIL full_words got %0d expected 256", words_loaded); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL full_writes_missing got %0d pending expected 0", exp_q.size()); end
    $display("count 256 loaded: words=%0d", words_loaded);
  endtask

  task automatic test_zero_count();
    int s0;
    pulse_load_req();
    s0 = start_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    // load_req outside DONE/ERROR must be ignored.
    pulse_load_req();
    send_byte(8'h00, 0);
    checks += 2;
    if (cpu_start !== 1'b1) begin errors++; $display("FAIL zero_start got %b expected 1", cpu_start); end
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b expected 1", done); end
    tick();
    checks += 2;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL zero_start_count got %0d expected 1", start_cnt - s0); end
    if (words_loaded !== 9'd0) begin errors++; $display("FAIL zero_words got %0d expected 0", words_loaded); end
    $display("zero count: done=%b", done);
  endtask

  task automatic test_idle_gaps();
    int s0;
    pulse_load_req();
    s0 = start_cnt;
    send_image(first_image(), 3, 0);
    tick();
    checks += 4;
    if (done !== 1'b1) begin errors++; $display("FAIL gaps_done got %b expected 1", done); end
    if (words_loaded !== 9'd2) begin errors++; $display("FAIL gaps_words got %0d expected 2", words_loaded); end
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL gaps_start_count got %0d expected 1", start_cnt - s0); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL gaps_writes_missing got %0d pending expected 0", exp_q.size()); end
    $display("idle gaps: done=%b", done);
  endtask

  task automatic test_reset_midload();
    bytes_t img;
    int s0;
    pulse_load_req();
    img = first_image();
    for (int i = 0; i < 5; i++) send_byte(img[i], 0);
    // Sixth byte would complete word 0; reset on that same edge drops it.
    rx_valid = 1'b1; rx_data = img[5]; RST_N = 1'b0;
    tick();
    RST_N = 1'b1; rx_valid = 1'b0;
    checks += 4;
    if (im_we !== 1'b0) begin errors++; $display("FAIL midrst_im_we got %b expected 0", im_we); end
    if (words_loaded !== 9'd0) begin errors++; $display("FAIL midrst_words got %0d expected 0", words_loaded); end
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL midrst_rx_ready got %b expected 1", rx_ready); end
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL midrst_hold got %b expected 1", cpu_hold); end
    send_image(first_image(), 0, 0);
    tick();
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL midrst_done got %b expected 1", done); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL midrst_writes_missing got %0d pending expected 0", exp_q.size()); end
    $display("reset mid-load recovered: done=%b", done);
    // Restart from DONE with a different one-word image.
    pulse_load_req();
    checks += 3;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL restart_hold got %b expected 1", cpu_hold); end
    if (words_loaded !== 9'd0) begin errors++; $display("FAIL restart_words got %0d expected 0", words_loaded); end
    if (done !== 1'b0) begin errors++; $display("FAIL restart_done got %b expected 0", done); end
    s0 = start_cnt;
    img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    send_image(img, 0, 0);
    tick();
    checks += 5;
    if (done !== 1'b1) begin errors++; $display("FAIL restart_done2 got %b expected 1", done); end
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL restart_hold2 got %b expected 0", cpu_hold); end
    if (words_loaded !== 9'd1) begin errors++; $display("FAIL restart_words2 got %0d expected 1", words_loaded); end
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL restart_start_count got %0d expected 1", start_cnt - s0); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL restart_writes_missing got %0d pending expected 0", exp_q.size()); end
    $display("restart image: done=%b words=%0d", done, words_loaded);
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_bad_checksum();
    test_count_limits();
    test_zero_count();
    test_idle_gaps();
    test_reset_midload();
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_program_loader.md
# nn_program_loader

Boot-time writer for the NN CPU's instruction memory. It accepts a byte stream of the form {word count, big-endian 32-bit instructions, XOR checksum}. Each assembled instruction is written into instruction memory at consecutive word addresses starting from 0. The block holds the CPU in reset-equivalent stall (`cpu_hold`) until the image is verified, then releases it with a one-cycle `cpu_start`. It sits between the host/serial byte source and the instruction memory write port, on the side opposite the CPU's PC-driven read port.

## Interface
Parameters:
- BUS_WIDTH, 32, instruction word width (fixed at 32; byte assembly assumes 4 bytes)
- ADDR_WIDTH, 8, instruction memory word-address width; depth = 2^ADDR_WIDTH

Ports:
- CLK  input  1  clock, all state changes on rising edge
- RST_N  input  1  reset; synchronous, active-low
- rx_valid  input  1  byte source has `rx_data` valid
- rx_data  input  8  stream byte
- rx_ready  output  1  loader can accept a byte; a byte transfers on an edge with rx_valid & rx_ready
- load_req  input  1  restart request, honoured only in DONE or ERROR
- im_we  output  1  instruction memory write enable, one-cycle pulse per word
- im_addr  output  ADDR_WIDTH  write word address
- im_wdata  output  BUS_WIDTH  write data
- cpu_hold  output  1  1 = CPU must not advance PC or fetch
- cpu_start  output  1  one-cycle pulse when a verified image is released
- done  output  1  image loaded and checksum good
- err  output  1  load failed: over-length count or bad checksum
- words_loaded  output  ADDR_WIDTH+1  number of words written so far

## Operation
- States: HDR_HI, HDR_LO, WORD, CSUM, DONE, ERROR. rx_ready = 1 in HDR_HI, HDR_LO, WORD and CSUM; 0 in DONE and ERROR. rx_ready is decoded from the state register only.
- HDR_HI: accepted byte becomes count[15:8]; go to HDR_LO.
- HDR_LO: accepted byte becomes count[7:0].
  - If count > 2^ADDR_WIDTH, go to ERROR.
  - If count = 0, go to CSUM.
  - Otherwise go to WORD with byte index 0.
- WORD: bytes shift in big-endian (first byte lands in [31:24]). On acceptance of byte index 3:
  - Register im_wdata = assembled word and im_addr = words_loaded[ADDR_WIDTH-1:0].
  - Set im_we = 1 for the next cycle only, and increment words_loaded.
  - If words_loaded + 1 = count, go to CSUM; otherwise reset byte index to 0.
- Running checksum: XOR of every accepted byte from HDR_HI through the last WORD byte. The running value resets to 0 on entry to HDR_HI.
- CSUM: accepted byte is compared with the running XOR.
  - Equal: go to DONE.
  - Not equal: go to ERROR.
- DONE: cpu_hold = 0 and done = 1. cpu_start = 1 in the first DONE cycle only.
- ERROR: err = 1 and cpu_hold stays 1. Words already written are not erased.
- load_req = 1 in DONE or ERROR: on the next edge go to HDR_HI and clear done, err, words_loaded and the checksum. cpu_hold returns to 1 on that edge. load_req is ignored in all other states.
- Width rules:
  - count is 16 bits.
  - words_loaded is ADDR_WIDTH+1 bits so that a full-depth count of 2^ADDR_WIDTH is representable.
  - im_addr wraps nowhere, because over-length counts are rejected.

## Timing
- Reset (RST_N = 0 at an edge) puts the block in HDR_HI with:
  - rx_ready = 1 from the following cycle
  - cpu_hold = 1
  - im_we = 0, im_addr = 0, im_wdata = 0
  - cpu_start = 0, done = 0, err = 0, words_loaded = 0
- Reset mid-load abandons the partial word and checksum immediately. A write pulse pending in that cycle is dropped.
- Throughput: one byte per cycle; there is no internal stall. A write pulse overlaps acceptance of the next word's first byte.
- Write latency: im_we is high in the cycle immediately after the edge that accepted the 4th byte of the word.
- Release latency: cpu_start and cpu_hold = 0 appear in the cycle immediately after the edge that accepted a matching checksum.
- rx_valid = 0 cycles are idle and change no state. The source may hold rx_valid high while rx_ready = 0; no byte is consumed in that case.
- All outputs are registered, except rx_ready, which is state-decoded.

## Test plan
- Stream 00 02 12 34 56 78 A0 00 00 01 AB, back-to-back -> im_we pulses at addr 0 with 0x12345678 and at addr 1 with 0xA0000001; done = 1; single cpu_start pulse; cpu_hold falls the cycle after the AB byte; words_loaded = 2.
- Same stream with checksum byte AC -> two writes occur, err = 1, done = 0, no cpu_start, cpu_hold stays 1, rx_ready = 0.
- Stream 01 01 (count 257, ADDR_WIDTH = 8) -> ERROR right after the second byte, no im_we, err = 1. Count 01 00 (256) is accepted and fills addr 0..255.
- Stream 00 00 00 -> no writes, done = 1, cpu_start pulses.
- First stream with a random 0–3 idle cycles between bytes -> identical writes and result; no byte is lost or duplicated.
- Reset asserted after byte 6 of the first stream, then the full stream resent -> only post-reset writes appear, with correct data. Then load_req in DONE followed by a new image -> cpu_hold returns to 1, words_loaded = 0, and the new image is loaded and released.
